// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: closes the loop around an external 1-cycle PC register,
// fetches over req/ack, delivers over valid/ready, and handles redirects and HALT.
module fetch_sequencer #(
   parameter int          ADDR_W   = 8,
   parameter int          INSTR_W  = 16,
   parameter int          STEP     = 2,
   parameter int          RESET_PC = 0,
   parameter logic [3:0]  HALT_OP  = 4'hF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  pc_output,
   output logic [ADDR_W-1:0]  pc_input,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr_out,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_target,
   output logic               halted
);

   typedef enum logic [1:0] {
      SETTLE  = 2'd0,
      FETCH   = 2'd1,
      DELIVER = 2'd2,
      HALT    = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [ADDR_W-1:0]    r_pc_input;
   logic [ADDR_W-1:0]    w_pc_input_next;
   logic [INSTR_W-1:0]   r_instr_out;
   logic [INSTR_W-1:0]   w_instr_out_next;
   logic                 r_imem_req;
   logic                 r_instr_valid;
   logic                 r_halted;
   logic                 w_redirect;
   logic                 w_ack;
   logic                 w_is_halt;

   // HALT ignores redirects; an ack only counts while a request is actually outstanding.
   assign w_redirect = redirect_valid && (r_state != HALT);
   assign w_ack      = imem_ack && r_imem_req && (r_state == FETCH);
   assign w_is_halt  = (r_instr_out[INSTR_W-1:INSTR_W-4] == HALT_OP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= SETTLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         SETTLE:  w_state_next = w_redirect ? SETTLE : FETCH;
         FETCH: begin
            if (w_redirect)  w_state_next = SETTLE;
            else if (w_ack)  w_state_next = DELIVER;
         end
         DELIVER: begin
            if (w_redirect)       w_state_next = SETTLE;
            else if (instr_ready) w_state_next = w_is_halt ? HALT : FETCH;
         end
         HALT:    w_state_next = HALT;
         default: w_state_next = SETTLE;
      endcase
   end

   // Redirect wins over the ack in the same cycle, so the fetched word is dropped.
   always_comb begin
      w_pc_input_next  = r_pc_input;
      w_instr_out_next = r_instr_out;
      if (w_redirect) begin
         w_pc_input_next = redirect_target & {{(ADDR_W-1){1'b1}}, 1'b0};
      end else if (w_ack) begin
         w_pc_input_next  = pc_output + ADDR_W'(STEP);
         w_instr_out_next = imem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc_input    <= ADDR_W'(RESET_PC);
         r_instr_out   <= '0;
         r_imem_req    <= 1'b0;
         r_instr_valid <= 1'b0;
         r_halted      <= 1'b0;
      end else begin
         r_pc_input    <= w_pc_input_next;
         r_instr_out   <= w_instr_out_next;
         r_imem_req    <= (w_state_next == FETCH);
         r_instr_valid <= (w_state_next == DELIVER);
         r_halted      <= (w_state_next == HALT);
      end
   end

   assign pc_input    = r_pc_input;
   assign imem_req    = r_imem_req;
   assign imem_addr   = pc_output;
   assign instr_out   = r_instr_out;
   assign instr_valid = r_instr_valid;
   assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; models the 1-cycle PC register locally.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  pc_output;
   logic [7:0]  pc_input;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_rdata = '0;
   logic [15:0] instr_out;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [7:0]  redirect_target = '0;
   logic        halted;

   int checks = 0;
   int errors = 0;

   fetch_sequencer dut (
      .clk             (clk),
      .rst             (rst),
      .pc_output       (pc_output),
      .pc_input        (pc_input),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .instr_out       (instr_out),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .halted          (halted)
   );

   always #5 clk = ~clk;

   // External PC register: one cycle from pc_input to pc_output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pc_output <= 8'h00;
      else      pc_output <= pc_input;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req();
      int n = 0;
      while (imem_req !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk("req_wait", 32'(imem_req), 32'(1));
   endtask

   // Fetch one word at exp_addr, leaving the sequencer in DELIVER.
   task automatic fetch_one(input logic [7:0] exp_addr, input logic [15:0] data,
                            input logic [7:0] exp_pc);
      wait_req();
      chk("fetch_addr", 32'(imem_addr), 32'(exp_addr));
      imem_ack   = 1'b1;
      imem_rdata = data;
      tick();
      imem_ack   = 1'b0;
      chk("deliver_valid", 32'(instr_valid), 32'(1));
      chk("deliver_instr", 32'(instr_out), 32'(data));
      chk("deliver_pc_input", 32'(pc_input), 32'(exp_pc));
      chk("deliver_req_low", 32'(imem_req), 32'(0));
      $display("fetch addr=%02h data=%04h pc_input=%02h", exp_addr, data, pc_input);
   endtask

   task automatic accept();
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("accept_valid_low", 32'(instr_valid), 32'(0));
   endtask

   initial begin
      // Reset values
      tick();
      tick();
      chk("rst_pc_input", 32'(pc_input), 32'(0));
      chk("rst_req", 32'(imem_req), 32'(0));
      chk("rst_valid", 32'(instr_valid), 32'(0));
      chk("rst_instr", 32'(instr_out), 32'(0));
      chk("rst_halted", 32'(halted), 32'(0));
      rst = 1'b1;
      chk("settle_req", 32'(imem_req), 32'(0));
      tick();
      chk("first_req", 32'(imem_req), 32'(1));
      chk("first_addr", 32'(imem_addr), 32'(0));

      // Sequential stepping with immediate ack and ready
      for (int i = 0; i < 5; i++) begin
         fetch_one(8'(2 * i), 16'(16'h1000 + i), 8'(2 * i + 2));
         accept();
      end

      // Decode stall holds the instruction and suppresses new requests
      fetch_one(8'h0A, 16'h1234, 8'h0C);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_valid", 32'(instr_valid), 32'(1));
         chk("stall_instr", 32'(instr_out), 32'(16'h1234));
         chk("stall_req", 32'(imem_req), 32'(0));
      end
      accept();
      chk("post_stall_req", 32'(imem_req), 32'(1));
      chk("post_stall_addr", 32'(imem_addr), 32'(8'h0C));

      // Redirect while FETCH waits without ack
      tick();
      chk("wait_req_held", 32'(imem_req), 32'(1));
      chk("wait_addr_held", 32'(imem_addr), 32'(8'h0C));
      redirect_valid  = 1'b1;
      redirect_target = 8'h41;
      tick();
      redirect_valid  = 1'b0;
      chk("redir_pc_input", 32'(pc_input), 32'(8'h40));
      chk("redir_settle_req", 32'(imem_req), 32'(0));
      tick();
      chk("redir_req", 32'(imem_req), 32'(1));
      chk("redir_addr", 32'(imem_addr), 32'(8'h40));
      $display("redirect target=41 next_addr=%02h", imem_addr);

      // Redirect and ack together: the word is discarded
      redirect_valid  = 1'b1;
      redirect_target = 8'h20;
      imem_ack        = 1'b1;
      imem_rdata      = 16'hBEEF;
      tick();
      redirect_valid  = 1'b0;
      imem_ack        = 1'b0;
      chk("drop_valid", 32'(instr_valid), 32'(0));
      chk("drop_pc_input", 32'(pc_input), 32'(8'h20));
      chk("drop_req", 32'(imem_req), 32'(0));
      tick();
      chk("drop_valid2", 32'(instr_valid), 32'(0));
      chk("drop_next_addr", 32'(imem_addr), 32'(8'h20));
      $display("redirect+ack target=20 next_addr=%02h", imem_addr);

      // Redirect squashes a delivered instruction even with ready high
      fetch_one(8'h20, 16'h5555, 8'h22);
      redirect_valid  = 1'b1;
      redirect_target = 8'hFE;
      instr_ready     = 1'b1;
      tick();
      redirect_valid  = 1'b0;
      instr_ready     = 1'b0;
      chk("squash_valid", 32'(instr_valid), 32'(0));
      chk("squash_pc_input", 32'(pc_input), 32'(8'hFE));
      $display("squash target=fe");

      // Address wrap 8'hFE -> 8'h00
      fetch_one(8'hFE, 16'h2222, 8'h00);
      accept();
      chk("wrap_addr", 32'(imem_addr), 32'(8'h00));

      // HALT: terminal until reset, ignores redirect and ack
      fetch_one(8'h00, 16'hF000, 8'h02);
      accept();
      chk("halt_flag", 32'(halted), 32'(1));
      chk("halt_req", 32'(imem_req), 32'(0));
      redirect_valid  = 1'b1;
      redirect_target = 8'h80;
      imem_ack        = 1'b1;
      tick();
      tick();
      redirect_valid  = 1'b0;
      imem_ack        = 1'b0;
      chk("halt_hold", 32'(halted), 32'(1));
      chk("halt_pc_hold", 32'(pc_input), 32'(8'h02));
      chk("halt_req_hold", 32'(imem_req), 32'(0));
      chk("halt_valid_hold", 32'(instr_valid), 32'(0));
      $display("halt pc_input=%02h halted=%0b", pc_input, halted);

      // Asynchronous reset out of HALT
      rst = 1'b0;
      #1;
      chk("async_rst_halted", 32'(halted), 32'(0));
      chk("async_rst_pc", 32'(pc_input), 32'(0));
      tick();
      rst = 1'b1;
      tick();
      fetch_one(8'h00, 16'h0ABC, 8'h02);

      // Asynchronous reset mid-deliver
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(instr_valid), 32'(0));
      chk("mid_rst_instr", 32'(instr_out), 32'(0));
      chk("mid_rst_pc", 32'(pc_input), 32'(0));
      chk("mid_rst_req", 32'(imem_req), 32'(0));
      tick();
      rst = 1'b1;
      fetch_one(8'h00, 16'h0123, 8'h02);
      accept();
      chk("restart_addr", 32'(imem_addr), 32'(8'h02));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
